// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch controller: button sync/edge detect, run/pause/lap FSM, MM:SS.cc BCD count.
// Define STOPWATCH_LAP_EN to build the lap-freeze states and lap register.
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic [3:0] cs_u,
  output logic [3:0] cs_t,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP, S_LAPP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;
`endif

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d, lap_sync_q, lap_sync_d;
  logic ss_hist_q, ss_hist_d, lap_hist_q, lap_hist_d;
  logic ss_ev, lap_ev;

  logic [3:0] cs_u_q, cs_u_d, cs_t_q, cs_t_d, sec_u_q, sec_u_d, min_u_q, min_u_d;
  logic [2:0] sec_t_q, sec_t_d, min_t_q, min_t_d;
  logic       wrap_q, wrap_d;
  logic       clear, count_en;
  logic [21:0] live_vec;

`ifdef STOPWATCH_LAP_EN
  logic [21:0] lap_q, lap_d;
  logic        capture;
`endif

  always_comb begin
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], btn_ss};
    lap_sync_d = {lap_sync_q[SYNC_STAGES-2:0], btn_lap};
    ss_hist_d  = ss_sync_q[SYNC_STAGES-1];
    lap_hist_d = lap_sync_q[SYNC_STAGES-1];
    ss_ev      = ss_sync_q[SYNC_STAGES-1] & ~ss_hist_q;
    // start/stop takes priority when both buttons edge together
    lap_ev     = lap_sync_q[SYNC_STAGES-1] & ~lap_hist_q & ~ss_ev;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    capture = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (ss_ev) state_d = S_RUN;
      S_RUN: begin
        if (ss_ev) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_ev) begin
          state_d = S_LAP;
          capture = 1'b1;
        end
`endif
      end
      S_PAUSE: begin
        if (ss_ev) state_d = S_RUN;
        else if (lap_ev) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (ss_ev)       state_d = S_LAPP;
        else if (lap_ev) state_d = S_RUN;
      end
      S_LAPP: begin
        if (ss_ev)       state_d = S_LAP;
        else if (lap_ev) state_d = S_PAUSE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  assign count_en   = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP) || (state_q == S_LAPP);
`else
  assign count_en   = (state_q == S_RUN);
  assign lap_active = 1'b0;
`endif
  assign running = count_en;

  assign live_vec = {min_t_q, min_u_q, sec_t_q, sec_u_q, cs_t_q, cs_u_q};

  // Cascaded BCD increment; a digit moves only when every lower digit is at its max.
  always_comb begin
    cs_u_d  = cs_u_q;
    cs_t_d  = cs_t_q;
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    wrap_d  = 1'b0;
    if (clear) begin
      cs_u_d  = 4'd0;
      cs_t_d  = 4'd0;
      sec_u_d = 4'd0;
      sec_t_d = 3'd0;
      min_u_d = 4'd0;
      min_t_d = 3'd0;
    end else if (tick && count_en) begin
      if (cs_u_q != 4'd9) cs_u_d = cs_u_q + 4'd1;
      else begin
        cs_u_d = 4'd0;
        if (cs_t_q != 4'd9) cs_t_d = cs_t_q + 4'd1;
        else begin
          cs_t_d = 4'd0;
          if (sec_u_q != 4'd9) sec_u_d = sec_u_q + 4'd1;
          else begin
            sec_u_d = 4'd0;
            if (sec_t_q != 3'd5) sec_t_d = sec_t_q + 3'd1;
            else begin
              sec_t_d = 3'd0;
              if (min_u_q != 4'd9) min_u_d = min_u_q + 4'd1;
              else begin
                min_u_d = 4'd0;
                if (min_t_q != 3'd5) min_t_d = min_t_q + 3'd1;
                else begin
                  min_t_d = 3'd0;
                  wrap_d  = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_comb begin
    lap_d = lap_q;
    if (clear)        lap_d = '0;
    else if (capture) lap_d = live_vec;
  end

  always_comb begin
    if (lap_active) {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = lap_q;
    else            {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = live_vec;
  end
`else
  assign {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = live_vec;
`endif

  assign wrap = wrap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ss_sync_q  <= '0;
      lap_sync_q <= '0;
      ss_hist_q  <= 1'b0;
      lap_hist_q <= 1'b0;
      cs_u_q     <= 4'd0;
      cs_t_q     <= 4'd0;
      sec_u_q    <= 4'd0;
      sec_t_q    <= 3'd0;
      min_u_q    <= 4'd0;
      min_t_q    <= 3'd0;
      wrap_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ss_sync_q  <= ss_sync_d;
      lap_sync_q <= lap_sync_d;
      ss_hist_q  <= ss_hist_d;
      lap_hist_q <= lap_hist_d;
      cs_u_q     <= cs_u_d;
      cs_t_q     <= cs_t_d;
      sec_u_q    <= sec_u_d;
      sec_t_q    <= sec_t_d;
      min_u_q    <= min_u_d;
      min_t_q    <= min_t_d;
      wrap_q     <= wrap_d;
`ifdef STOPWATCH_LAP_EN
      lap_q      <= lap_d;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; display compared as 24'hMMSSCC with each digit in its own nibble.
module tb_stopwatch_ctrl;
  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, btn_ss = 1'b0, btn_lap = 1'b0;
  logic [3:0] cs_u, cs_t, sec_u, min_u;
  logic [2:0] sec_t, min_t;
  logic       running, lap_active, wrap;
  logic [23:0] disp;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .cs_u(cs_u), .cs_t(cs_t), .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  assign disp = {1'b0, min_t, min_u, 1'b0, sec_t, sec_u, cs_t, cs_u};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  // Button(s) rise, state moves two edges later; tk puts a tick on that transition edge.
  task automatic press(input logic ss, input logic lp, input logic tk);
    btn_ss = ss; btn_lap = lp;
    repeat (2) @(negedge clk);
    tick = tk;
    @(negedge clk);
    tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_disp", disp, 24'h000000);
    chk("rst_running", {23'd0, running}, 24'd0);
    chk("rst_lap_active", {23'd0, lap_active}, 24'd0);
    chk("rst_wrap", {23'd0, wrap}, 24'd0);
    rst = 1'b1;
    @(negedge clk);

    ticks(20);
    chk("idle_ticks", disp, 24'h000000);

    press(1'b1, 1'b0, 1'b1);
    chk("start_running", {23'd0, running}, 24'd1);
    chk("start_tick_ignored", disp, 24'h000000);

    ticks(150);
    chk("run_150", disp, 24'h000150);
    chk("run_running", {23'd0, running}, 24'd1);
    ticks(50);
    chk("run_200", disp, 24'h000200);

`ifdef STOPWATCH_LAP_EN
    press(1'b0, 1'b1, 1'b1);
    chk("lap_freeze", disp, 24'h000200);
    chk("lap_active", {23'd0, lap_active}, 24'd1);
    chk("lap_running", {23'd0, running}, 24'd1);
    ticks(99);
    chk("lap_hold", disp, 24'h000200);
    press(1'b0, 1'b1, 1'b0);
    chk("lap_release", disp, 24'h000300);
    chk("lap_release_flag", {23'd0, lap_active}, 24'd0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("lapp_running", {23'd0, running}, 24'd0);
    chk("lapp_active", {23'd0, lap_active}, 24'd1);
    ticks(10);
    chk("lapp_frozen", disp, 24'h000300);
    press(1'b0, 1'b1, 1'b0);
    chk("lapp_to_pause", {22'd0, lap_active, running}, 24'd0);
    chk("lapp_to_pause_disp", disp, 24'h000300);
    press(1'b1, 1'b0, 1'b0);
    chk("resume_run", {23'd0, running}, 24'd1);
`else
    press(1'b0, 1'b1, 1'b1);
    chk("nolap_disp", disp, 24'h000201);
    chk("nolap_flags", {22'd0, lap_active, running}, 24'd1);
    ticks(99);
    chk("nolap_300", disp, 24'h000300);
`endif

    press(1'b1, 1'b0, 1'b1);
    chk("stop_tick_counted", disp, 24'h000301);
    chk("pause_running", {23'd0, running}, 24'd0);
    ticks(50);
    chk("pause_frozen", disp, 24'h000301);

    press(1'b1, 1'b0, 1'b0);
    chk("resume", {23'd0, running}, 24'd1);
    press(1'b1, 1'b1, 1'b0);
    chk("both_flags", {22'd0, lap_active, running}, 24'd0);
    ticks(50);
    chk("both_frozen", disp, 24'h000301);

    press(1'b0, 1'b1, 1'b0);
    chk("clear_disp", disp, 24'h000000);
    chk("clear_running", {23'd0, running}, 24'd0);

    btn_ss = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_one_event", {23'd0, running}, 24'd1);
    btn_ss = 1'b0;
    repeat (3) @(negedge clk);
    ticks(37);
    chk("run_37", disp, 24'h000037);
    press(1'b1, 1'b0, 1'b0);
    chk("pause_37", disp, 24'h000037);
    press(1'b0, 1'b1, 1'b1);
    chk("clear_tick_ignored", disp, 24'h000000);
    chk("clear_idle", {23'd0, running}, 24'd0);

    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    // preload the paused count rather than spend ~360k ticks
    force dut.min_t_q = 3'd0; force dut.min_u_q = 4'd9;
    force dut.sec_t_q = 3'd5; force dut.sec_u_q = 4'd9;
    force dut.cs_t_q = 4'd9;  force dut.cs_u_q = 4'd9;
    #1;
    release dut.min_t_q; release dut.min_u_q; release dut.sec_t_q;
    release dut.sec_u_q; release dut.cs_t_q;  release dut.cs_u_q;
    @(negedge clk);
    chk("preload_9", disp, 24'h095999);
    press(1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("min_carry", disp, 24'h100000);
    press(1'b1, 1'b0, 1'b0);
    force dut.min_t_q = 3'd5; force dut.min_u_q = 4'd9;
    force dut.sec_t_q = 3'd5; force dut.sec_u_q = 4'd9;
    force dut.cs_t_q = 4'd9;  force dut.cs_u_q = 4'd8;
    #1;
    release dut.min_t_q; release dut.min_u_q; release dut.sec_t_q;
    release dut.sec_u_q; release dut.cs_t_q;  release dut.cs_u_q;
    @(negedge clk);
    chk("preload_wrap", disp, 24'h595998);
    press(1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("pre_wrap", disp, 24'h595999);
    chk("pre_wrap_flag", {23'd0, wrap}, 24'd0);
    ticks(1);
    chk("wrap_disp", disp, 24'h000000);
    chk("wrap_pulse", {23'd0, wrap}, 24'd1);
    chk("wrap_still_run", {23'd0, running}, 24'd1);
    @(negedge clk);
    chk("wrap_one_cycle", {23'd0, wrap}, 24'd0);

    ticks(512);
    chk("run_512", disp, 24'h000512);
    press(1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
    chk("lap_512", {22'd0, lap_active, running}, 24'd3);
    ticks(3);
    chk("lap_512_hold", disp, 24'h000512);
`else
    chk("nolap_512", {22'd0, lap_active, running}, 24'd1);
    ticks(3);
    chk("nolap_515", disp, 24'h000515);
`endif
    #2 rst = 1'b0;
    #1;
    chk("async_rst_disp", disp, 24'h000000);
    chk("async_rst_flags", {21'd0, wrap, lap_active, running}, 24'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {22'd0, lap_active, running}, 24'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
